// File: rtl/sort_sched_pkg.sv
// Shared types and default sizing for the sort_sched scheduler.
package sort_sched_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned SORT_SCHED_WIDTH = 3;
  localparam int unsigned SORT_SCHED_NREQ  = 4;
endpackage

// File: rtl/sort_sched_sort3_core.sv
// Combinational three-input sorter built from three compare-swaps.
// Output order follows SORT_SCHED_DESC_EN (defined: o_no1 largest; undefined: o_no1 smallest).
module sort3_core #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_no1,
  output logic [WIDTH-1:0] o_no2,
  output logic [WIDTH-1:0] o_no3
);
  logic [WIDTH-1:0] w_s0, w_s1, w_t1, w_t2, w_u0, w_u1;

  // w_t2 is the overall max after stage two; stage three orders the remaining pair.
  always_comb begin
    w_s0 = (i_a > i_b) ? i_b : i_a;
    w_s1 = (i_a > i_b) ? i_a : i_b;
    w_t1 = (w_s1 > i_c) ? i_c : w_s1;
    w_t2 = (w_s1 > i_c) ? w_s1 : i_c;
    w_u0 = (w_s0 > w_t1) ? w_t1 : w_s0;
    w_u1 = (w_s0 > w_t1) ? w_s0 : w_t1;
  end

`ifdef SORT_SCHED_DESC_EN
  assign o_no1 = w_t2;
  assign o_no2 = w_u1;
  assign o_no3 = w_u0;
`else
  assign o_no1 = w_u0;
  assign o_no2 = w_u1;
  assign o_no3 = w_t2;
`endif
endmodule

// File: rtl/sort_sched.sv
// Round-robin scheduler sharing one 3-operand sorter among NREQ requesters.
// Sort order selected by SORT_SCHED_DESC_EN (see sort3_core).
module sort_sched
  import sort_sched_pkg::*;
#(
  parameter int unsigned WIDTH = SORT_SCHED_WIDTH,
  parameter int unsigned NREQ  = SORT_SCHED_NREQ,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*WIDTH-1:0] req_c,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      no1,
  output logic [WIDTH-1:0]      no2,
  output logic [WIDTH-1:0]      no3,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy
);
  state_t           r_state;
  logic [IDW-1:0]   r_rr;
  logic [IDW-1:0]   r_grant;
  logic [WIDTH-1:0] r_a, r_b, r_c;
  logic [WIDTH-1:0] r_no1, r_no2, r_no3;
  logic [NREQ-1:0]  r_resp_valid;

  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_rr_next;
  int unsigned      w_idx;
  logic [NREQ-1:0]  w_req_ready;
  logic [WIDTH-1:0] w_s1, w_s2, w_s3;

  // Round-robin search starting at r_rr, wrapping NREQ-1 -> 0.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = 32'(r_rr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(w_idx);
      end
    end
    w_rr_next = (32'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
  end

  always_comb begin
    w_req_ready = '0;
    if (rst && (r_state == IDLE) && w_found) w_req_ready[w_win] = 1'b1;
  end

  sort3_core #(.WIDTH(WIDTH)) u_sort3 (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_c   (r_c),
    .o_no1 (w_s1),
    .o_no2 (w_s2),
    .o_no3 (w_s3)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_rr         <= '0;
      r_grant      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_c          <= '0;
      r_no1        <= '0;
      r_no2        <= '0;
      r_no3        <= '0;
      r_resp_valid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a     <= req_a[32'(w_win)*WIDTH +: WIDTH];
            r_b     <= req_b[32'(w_win)*WIDTH +: WIDTH];
            r_c     <= req_c[32'(w_win)*WIDTH +: WIDTH];
            r_grant <= w_win;
            r_rr    <= w_rr_next;
            r_state <= SORT;
          end
        end
        SORT: begin
          r_no1                 <= w_s1;
          r_no2                 <= w_s2;
          r_no3                 <= w_s3;
          r_resp_valid          <= '0;
          r_resp_valid[r_grant] <= 1'b1;
          r_state               <= RESP;
        end
        RESP: begin
          if (resp_ready[r_grant]) begin
            r_resp_valid <= '0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = w_req_ready;
  assign resp_valid = r_resp_valid;
  assign no1        = r_no1;
  assign no2        = r_no2;
  assign no3        = r_no3;
  assign grant_id   = r_grant;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_sort_sched.sv
// Self-checking bench for sort_sched: transaction-level model plus directed scenarios.
module tb_sort_sched;
  localparam int W   = 3;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic [N-1:0]   req_ready, resp_valid;
  logic [N-1:0]   resp_ready = '1;
  logic [W-1:0]   no1, no2, no3;
  logic [IDW-1:0] grant_id;
  logic           busy;

  int n_pass = 0;
  int n_total = 0;

  sort_sched #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .no1(no1), .no2(no2), .no3(no3), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: job phase 0 = free, 1 = sorting, 2 = result offered.
  bit m_init = 0;
  int m_phase = 0, m_rr = 0, m_grant = 0;
  int m_a, m_b, m_c;
  int m_no[3] = '{0, 0, 0};

  function automatic int m_winner();
    for (int k = 0; k < N; k++)
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic ref_sort(input int a, input int b, input int c, output int o[3]);
    int lo, hi;
    lo = (a < b) ? a : b; lo = (lo < c) ? lo : c;
    hi = (a > b) ? a : b; hi = (hi > c) ? hi : c;
`ifdef SORT_SCHED_DESC_EN
    o = '{hi, a + b + c - lo - hi, lo};
`else
    o = '{lo, a + b + c - lo - hi, hi};
`endif
  endtask

  task automatic model_step();
    int w;
    if (!rst) begin
      m_init = 1; m_phase = 0; m_rr = 0; m_grant = 0; m_no = '{0, 0, 0};
    end else if (m_init) begin
      if (m_phase == 0) begin
        w = m_winner();
        if (w >= 0) begin
          m_a = int'(req_a[w*W +: W]); m_b = int'(req_b[w*W +: W]); m_c = int'(req_c[w*W +: W]);
          m_grant = w; m_rr = (w + 1) % N; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        ref_sort(m_a, m_b, m_c, m_no);
        m_phase = 2;
      end else if (resp_ready[m_grant]) begin
        m_phase = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [N-1:0] e_rdy, e_rv;
    int w;
    @(negedge clk);
    if (m_init) begin
      e_rdy = '0;
      if (rst && m_phase == 0) begin
        w = m_winner();
        if (w >= 0) e_rdy[w] = 1'b1;
      end
      e_rv = '0;
      if (m_phase == 2) e_rv[m_grant] = 1'b1;
      chk("m.req_ready", 32'(req_ready), 32'(e_rdy));
      chk("m.resp_valid", 32'(resp_valid), 32'(e_rv));
      chk("m.busy", 32'(busy), 32'(m_phase != 0));
      chk("m.grant_id", 32'(grant_id), 32'(m_grant));
      chk("m.no1", 32'(no1), 32'(m_no[0]));
      chk("m.no2", 32'(no2), 32'(m_no[1]));
      chk("m.no3", 32'(no3), 32'(m_no[2]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int r, input int a, input int b, input int c);
    req_a[r*W +: W] = W'(a);
    req_b[r*W +: W] = W'(b);
    req_c[r*W +: W] = W'(c);
  endtask

  task automatic chk_no(input string tag, input int lo, input int mid, input int hi);
`ifdef SORT_SCHED_DESC_EN
    chk({tag, ".no1"}, 32'(no1), 32'(hi));
    chk({tag, ".no2"}, 32'(no2), 32'(mid));
    chk({tag, ".no3"}, 32'(no3), 32'(lo));
`else
    chk({tag, ".no1"}, 32'(no1), 32'(lo));
    chk({tag, ".no2"}, 32'(no2), 32'(mid));
    chk({tag, ".no3"}, 32'(no3), 32'(hi));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; resp_ready = '1;
    tick(); tick();
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] oh;
    int a, b, c;

    // Reset values
    do_reset();
    chk("rst.busy", 32'(busy), 0);
    chk("rst.resp_valid", 32'(resp_valid), 0);
    chk("rst.grant_id", 32'(grant_id), 0);
    chk_no("rst", 0, 0, 0);

    // Single job on requester 0
    set_job(0, 6, 1, 4); req_valid = 4'b0001;
    #1 chk("single.req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0; set_job(0, 0, 7, 0);
    chk("single.busy_sort", 32'(busy), 1);
    chk("single.rv_sort", 32'(resp_valid), 0);
    tick();
    chk("single.rv_resp", 32'(resp_valid), 32'h1);
    chk_no("single", 1, 4, 6);
    tick();
    chk("single.rv_idle", 32'(resp_valid), 0);
    chk_no("single.hold", 1, 4, 6);

    // Contention: grant order 0,1,2,3,0, one acceptance per 3 cycles
    do_reset();
    set_job(1, 3, 2, 1); set_job(2, 7, 7, 0); set_job(3, 4, 0, 5);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = '0; oh[order[k]] = 1'b1;
      #1 chk("cont.req_ready", 32'(req_ready), 32'(oh));
      tick();
      chk("cont.grant_id", 32'(grant_id), 32'(order[k]));
      tick(); tick();
    end
    req_valid = '0;
    tick(); tick(); tick();

    // Backpressure on requester 2; foreign resp_ready ignored
    do_reset();
    set_job(2, 7, 0, 3); req_valid = 4'b0100; resp_ready = 4'b0010;
    #1 chk("bp.req_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1011;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp.resp_valid", 32'(resp_valid), 32'h4);
      chk("bp.req_ready_busy", 32'(req_ready), 0);
      chk("bp.busy", 32'(busy), 1);
      chk_no("bp", 0, 3, 7);
      tick();
    end
    resp_ready = 4'b0100;
    tick();
    chk("bp.rv_clear", 32'(resp_valid), 0);
    #1 chk("bp.rr_next", 32'(req_ready), 32'h8);
    req_valid = '0; resp_ready = '1;
    tick();
    chk("bp.cancel", 32'(busy), 0);

    // Reset while in SORT drops the job
    do_reset();
    set_job(1, 5, 5, 2); req_valid = 4'b0010;
    tick();
    req_valid = '0;
    chk("rstmid.busy_sort", 32'(busy), 1);
    rst = 1'b0;
    tick();
    chk("rstmid.busy", 32'(busy), 0);
    chk("rstmid.grant_id", 32'(grant_id), 0);
    chk_no("rstmid", 0, 0, 0);
    req_valid = 4'b0010;
    #1 chk("rstmid.ready_in_rst", 32'(req_ready), 0);
    req_valid = '0; rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstmid.no_resp", 32'(resp_valid), 0);
    end

    // Pointer wrap 3 -> 0, then pointer at 1
    do_reset();
    req_valid = 4'b1000; set_job(3, 2, 6, 1);
    #1 chk("wrap.ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    chk("wrap.grant3", 32'(grant_id), 3);
    tick(); tick();
    req_valid = 4'b0001;
    #1 chk("wrap.ready0", 32'(req_ready), 32'h1);
    tick();
    chk("wrap.grant0", 32'(grant_id), 0);
    req_valid = 4'b1111;
    tick(); tick();
    #1 chk("wrap.rr1", 32'(req_ready), 32'h2);
    req_valid = '0;
    tick();

    // Exhaustive triples through requester 3, operands scrambled after acceptance
    do_reset();
    for (int v = 0; v < 512; v++) begin
      a = (v >> 6) & 7; b = (v >> 3) & 7; c = v & 7;
      set_job(3, a, b, c); req_valid = 4'b1000;
      tick();
      req_valid = '0;
      set_job(3, $urandom_range(7), $urandom_range(7), $urandom_range(7));
      tick();
      if (a == 5 && b == 5 && c == 2) chk_no("exh.552", 2, 5, 5);
      if (a == 6 && b == 1 && c == 4) chk_no("exh.614", 1, 4, 6);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sort_sched.md
SORT_SCHED -- requirements
Module: sort_sched

Interface
REQ-001 Parameters SHALL be: WIDTH, default 3, bits per operand; NREQ, default 4, number of requesters; IDW, default 2, grant-id width (clog2 NREQ).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  NREQ  requester i has a 3-operand job.
REQ-005 req_a, req_b, req_c  in  NREQ*WIDTH  operands; requester i at bits [i*WIDTH +: WIDTH].
REQ-006 req_ready  out  NREQ  one-hot acceptance; at most one bit high per cycle.
REQ-007 resp_valid  out  NREQ  one-hot; result on no1..no3 belongs to that requester.
REQ-008 resp_ready  in  NREQ  requester i consumes its result.
REQ-009 no1, no2, no3  out  WIDTH  sorted result; no1 smallest, no3 largest (default order).
REQ-010 grant_id  out  IDW  index of the requester currently owning the sorter.
REQ-011 busy  out  1  high in any state other than IDLE.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, SORT, RESP.
REQ-013 IDLE: if any req_valid is high, req_ready SHALL go high for the winner in the same cycle (combinational from req_valid and rr pointer); on that edge operands latch, grant_id latches, state -> SORT.
REQ-014 Arbitration SHALL be round-robin: search starts at rr pointer and wraps NREQ-1 -> 0; after acceptance the pointer becomes (winner+1) mod NREQ.
REQ-015 req_ready SHALL be all-zero in SORT and RESP, and in IDLE when no req_valid is high.
REQ-016 SORT: sub-module computes the sorted triple; on the edge the result registers into no1..no3; state -> RESP (one cycle in SORT, always).
REQ-017 RESP: resp_valid[grant_id] SHALL be high and no1..no3 stable until resp_ready[grant_id] is high; on that edge state -> IDLE and resp_valid clears.
REQ-018 resp_ready bits other than resp_ready[grant_id] SHALL be ignored.
REQ-019 Latency: resp_valid SHALL assert exactly 2 cycles after the acceptance edge; back-to-back throughput is one job per 3 cycles with immediate resp_ready.
REQ-020 Equal operands SHALL produce equal adjacent outputs (e.g. 5,5,2 -> 2,5,5); all 2^(3*WIDTH) operand combinations SHALL sort correctly.
REQ-021 req_valid dropping before acceptance SHALL cancel that request with no side effect; operand changes after acceptance SHALL not affect the result.
REQ-022 no1..no3 SHALL retain the last result in IDLE and SORT.

Reset
REQ-023 With rst low at a rising edge: state IDLE, rr pointer 0, grant_id 0, no1..no3 0, resp_valid 0, busy 0.
REQ-024 req_ready SHALL be forced all-zero while rst is low.
REQ-025 Reset in SORT or RESP SHALL drop the in-flight job; no resp_valid for it afterwards.

Configuration
REQ-026 Macro SORT_SCHED_DESC_EN: when defined, no1 SHALL be largest and no3 smallest; when undefined, ascending order per REQ-009. Latency, handshake and reset values SHALL be identical in both builds.

Structure
REQ-027 Package sort_sched_pkg SHALL hold the state enum (IDLE, SORT, RESP) and default WIDTH/NREQ constants.
REQ-028 One sub-module, sort3_core: purely combinational 3-input sorter (three compare-swaps), ordered per REQ-026; all registers live in sort_sched.

Verification
REQ-029 Single job: reset, req_valid[0]=1, a=6,b=1,c=4 -> req_ready[0] same cycle, resp_valid[0] 2 cycles later, no1..no3 = 1,4,6.
REQ-030 Contention: req_valid=4'b1111 held, resp_ready all high -> grant order 0,1,2,3,0, one acceptance per 3 cycles.
REQ-031 Backpressure: job 7,0,3 on requester 2, resp_ready[2]=0 for 5 cycles, resp_ready[1]=1 -> resp_valid[2] and 0,3,7 held 5 cycles, no new acceptance, busy=1.
REQ-032 Reset mid-job: accept 5,5,2 on requester 1, drop rst in SORT -> outputs 0, state IDLE, no resp_valid[1] after.
REQ-033 Exhaustive: all 512 triples for WIDTH=3 through requester 3 -> match a reference model; repeated with SORT_SCHED_DESC_EN (e.g. 6,1,4 -> 6,4,1).
REQ-034 Pointer wrap: only req_valid[3] then only req_valid[0] -> grant_id 3 then 0, rr pointer 0 then 1.
